// File: rtl/brisc_pkg.sv
// Shared core constants and the fetch-stage state and queue-entry types.
package brisc_pkg;

    localparam int ILEN         = 32;
    localparam int ADDRESS_BITS = 32;
    localparam logic [ADDRESS_BITS-1:0] PC_BOOT = 32'h0000_1000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [ILEN-1:0]         instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with flush: push/pop may coincide (even when full), flush clears pointers.
module fetch_fifo
    import brisc_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_ONE;
            if (do_pop) head_d = head_q + PTR_ONE;
            if (push_i && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!push_i && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and queues
// returned instructions for decode; branch redirects flush the queue and kill in-flight fetches.
module ifetch_queue
    import brisc_pkg::*;
#(
    parameter int                ADDR_W   = ADDRESS_BITS,
    parameter int                INSTR_W  = ILEN,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BOOT_PC  = PC_BOOT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic               mem_resp,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               b_taken,
    input  logic [ADDR_W-1:0]  b_target,
    output fetch_state_e       dbg_state
);

    localparam int               CNT_W   = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              kill_q, kill_d;

    logic              push, pop;
    logic [CNT_W-1:0]  count, count_nx;
    entry_t            push_data, head;

    // Handshakes: a memory request transfers when mem_req && mem_ready (mem_req/mem_addr stay
    // stable until then); an instruction transfers to decode when instr_valid && instr_ready
    // and no redirect is active that cycle.
    assign push        = (state_q == FS_WAIT) && mem_resp && !b_taken;
    assign pop         = instr_valid && instr_ready && !b_taken;
    assign instr_valid = (count != '0);
    assign push_data   = '{pc: addr_q, instr: mem_rdata};

    // Occupancy after this cycle's push/pop/flush, used for the credit check on WAIT exit.
    always_comb begin
        count_nx = count;
        if (b_taken)           count_nx = '0;
        else if (push && !pop) count_nx = count + CNT_ONE;
        else if (!push && pop) count_nx = count - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        if (b_taken) pc_d = b_target & ~ADDR_W'(3);
        unique case (state_q)
            FS_IDLE: begin
                if (!b_taken && (count < DEPTH_C)) begin
                    state_d = FS_REQ;
                    addr_d  = pc_q;
                end
            end
            FS_REQ: begin
                if (mem_ready) begin
                    // A killed request already has the redirect target in pc_q.
                    if (!b_taken && !kill_q) pc_d = addr_q + ADDR_W'(4);
                    state_d = (kill_q || b_taken) ? FS_DRAIN : FS_WAIT;
                end else if (b_taken) begin
                    kill_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (mem_resp) begin
                    if (count_nx < DEPTH_C) begin
                        state_d = FS_REQ;
                        addr_d  = pc_d;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end else if (b_taken) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                if (mem_resp) begin
                    state_d = FS_IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            pc_q    <= BOOT_PC;
            addr_q  <= BOOT_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (FQ_DEPTH),
        .entry_t(entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush_i    (b_taken),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    assign mem_req   = (state_q == FS_REQ);
    assign mem_addr  = addr_q;
    assign instr     = head.instr;
    assign instr_pc  = head.pc;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic against a program-order model.
module tb_ifetch_queue;
    import brisc_pkg::*;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int EW = AW + IW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic          mem_resp = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          b_taken = 1'b0;
    logic [AW-1:0] b_target = '0;
    fetch_state_e  dbg_state;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .b_taken    (b_taken),
        .b_target   (b_target),
        .dbg_state  (dbg_state)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_pop = 0;
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] fill_pc = PC_BOOT;

    bit            pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            pend_dly = 0;
    int            rdy_pct = 100;
    int            dly_min = 0;
    int            dly_max = 0;
    int            dec_pct = 100;
    bit            br_req = 1'b0;
    logic [AW-1:0] br_tgt = '0;
    bit            mon_en = 1'b0;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [AW-1:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 'x;
    endfunction

    task automatic check_eq(input string name, input logic [EW:0] act, input logic [EW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: memory responder, decode ready, redirect; redirects re-seed the model.
    task automatic step();
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        if (pend) begin
            if (pend_dly == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = instr_of(pend_addr);
                pend      = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        mem_ready = (int'($urandom_range(100, 1)) <= rdy_pct);
        if (mem_req && mem_ready) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_dly  = int'($urandom_range(dly_max, dly_min));
            req_log.push_back(mem_addr);
        end
        instr_ready = (int'($urandom_range(100, 1)) <= dec_pct);
        b_taken     = br_req;
        b_target    = br_tgt;
        br_req      = 1'b0;
        if (b_taken) begin
            exp_q.delete();
            fill_pc = {b_target[AW-1:2], 2'b00};
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back({fill_pc, instr_of(fill_pc)});
            fill_pc = fill_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        mem_resp = 1'b0;
        b_taken  = 1'b0;
        pend     = 1'b0;
        br_req   = 1'b0;
        repeat (2) @(negedge clk);
        req_log.delete();
        exp_q.delete();
        fill_pc = PC_BOOT;
        reset   = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mem_req"}, mem_req, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, PC_BOOT);
        check_eq({tag, "_instr_valid"}, instr_valid, 0);
        check_eq({tag, "_instr"}, instr, 0);
        check_eq({tag, "_instr_pc"}, instr_pc, 0);
    endtask

    // Monitor: request-hold protocol and in-order delivery against the expected queue.
    initial begin : monitor
        logic [EW-1:0] e;
        bit            prev_stall;
        logic [AW-1:0] prev_addr;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || !reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check_eq("req_held", {mem_req, mem_addr}, {1'b1, prev_addr});
                prev_stall = mem_req && !mem_ready;
                prev_addr  = mem_addr;
                if (instr_valid && instr_ready && !b_taken) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL deliver_unexpected: got pc %h with empty expected queue", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("deliver", {instr_pc, instr}, e);
                    end
                end
            end
        end
    end

    initial begin : main
        int  k;
        bit  seen;
        int  pops0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst");

        // Sequential fetch with a 1-cycle memory; first valid one cycle after first response.
        rdy_pct = 100; dly_min = 0; dly_max = 0; dec_pct = 100;
        do_reset();
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            step();
            if (mem_resp) seen = 1'b1;
        end
        check_eq("t1_resp_seen", seen, 1);
        check_eq("t1_valid_before", instr_valid, 0);
        step();
        check_eq("t1_valid_after", instr_valid, 1);
        check_eq("t1_head_pc", instr_pc, 32'h1000);
        repeat (10) step();
        check_eq("t1_addr0", log_at(0), 32'h1000);
        check_eq("t1_addr1", log_at(1), 32'h1004);
        check_eq("t1_addr2", log_at(2), 32'h1008);

        // Decode stalled: exactly FQ_DEPTH requests, then resume at 0x1010.
        dec_pct = 0;
        do_reset();
        repeat (30) step();
        check_eq("t2_req_count", req_log.size(), 4);
        check_eq("t2_mem_req_off", mem_req, 0);
        check_eq("t2_idle", dbg_state, FS_IDLE);
        check_eq("t2_head_pc", instr_pc, 32'h1000);
        dec_pct = 100;
        repeat (12) step();
        check_eq("t2_resume_addr", log_at(4), 32'h1010);

        // Redirect while waiting for a response: response dropped, refetch at 0x2000.
        dec_pct = 0; dly_min = 3; dly_max = 3;
        do_reset();
        for (k = 0; k < 40 && req_log.size() < 2; k++) step();
        br_req = 1'b1; br_tgt = 32'h2002;
        step();
        step();
        check_eq("t3_flushed", instr_valid, 0);
        check_eq("t3_drain", dbg_state, FS_DRAIN);
        repeat (4) step();
        check_eq("t3_dropped", instr_valid, 0);
        repeat (4) step();
        check_eq("t3_refetch", log_at(2), 32'h2000);
        dec_pct = 100; dly_min = 0; dly_max = 0;
        repeat (10) step();

        // Redirect while a request is stalled: address held, response drained, then 0x2000.
        rdy_pct = 0;
        do_reset();
        k = 0;
        do begin step(); k++; end while (!mem_req && k < 10);
        br_req = 1'b1; br_tgt = 32'h2000;
        step();
        check_eq("t4_hold_a", {mem_req, mem_addr}, {1'b1, 32'h1000});
        step();
        check_eq("t4_hold_b", {mem_req, mem_addr}, {1'b1, 32'h1000});
        rdy_pct = 100;
        repeat (10) step();
        check_eq("t4_killed_addr", log_at(0), 32'h1000);
        check_eq("t4_new_addr", log_at(1), 32'h2000);

        // Full queue: redirect and pop in the same cycle, flush wins.
        dec_pct = 0;
        do_reset();
        repeat (30) step();
        check_eq("t5_full_valid", instr_valid, 1);
        pops0 = n_pop;
        dec_pct = 100; br_req = 1'b1; br_tgt = 32'h3000;
        step();
        step();
        check_eq("t5_flush_wins", instr_valid, 0);
        check_eq("t5_no_pop", n_pop, pops0);
        repeat (10) step();

        // Asynchronous reset in WAIT, then a stray response in IDLE.
        dec_pct = 0; dly_min = 2; dly_max = 2;
        do_reset();
        for (k = 0; k < 40 && req_log.size() < 2; k++) step();
        step();
        mon_en = 1'b0;
        #3 reset = 1'b0;
        #1 check_reset_outputs("t6_async");
        do_reset();
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        dec_pct = 100; dly_min = 0; dly_max = 0;
        repeat (10) step();
        check_eq("t6_boot_addr", log_at(0), PC_BOOT);

        // Randomized traffic with redirects.
        rdy_pct = 70; dly_min = 0; dly_max = 3; dec_pct = 60;
        do_reset();
        pops0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(25, 1) == 1) begin
                br_req = 1'b1;
                br_tgt = 32'h4000 + $urandom_range(1023, 0);
            end
            step();
        end
        check_eq("rand_progress", (n_pop - pops0) > 100, 1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
